// File: rtl/fp_mul_seq.sv
// fp_mul_seq: sequential IEEE-754-style multiplier.
// Rounding is round-to-nearest-even. Subnormal inputs and results are flushed to zero.
// The fraction product is built by a shift-add loop, one multiplier bit per cycle.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake; in_ready is high only in IDLE
//   in_a, in_b            operands {sign, exp, frac}
//   out_valid/out_ready   result handshake; out_valid is high only in DONE
//   out_data              product, held until the next result is produced
//   out_flags             {invalid, overflow, underflow, inexact}; present only
//                         when FP_MUL_FLAGS_EN is defined
module fp_mul_seq #(
  parameter int  EXP_W  = 8,
  parameter int  FRAC_W = 23,
  localparam int W      = 1 + EXP_W + FRAC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
`ifdef FP_MUL_FLAGS_EN
  ,
  output logic [3:0]   out_flags
`endif
);
  localparam int MW   = FRAC_W + 1;       // mantissa width including hidden bit
  localparam int PW   = 2 * MW;           // product width
  localparam int EW   = EXP_W + 2;        // signed working exponent width
  localparam int CW   = $clog2(MW + 1);
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam logic [EXP_W-1:0]     EMAX  = '1;
  localparam logic [W-1:0]         QNAN  = {1'b0, EMAX, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic signed [EW-1:0] E_INF = EW'(2 ** EXP_W - 1);
  localparam logic signed [EW-1:0] E_ONE = EW'(1);

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;
  state_t state, state_nxt;

  // operand fields and classification
  logic              sa, sb;
  logic [EXP_W-1:0]  ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special;
  logic [W-1:0]      spec_word;

  assign {sa, ea, fa} = in_a;
  assign {sb, eb, fb} = in_b;
  assign a_nan   = (ea == EMAX) && (fa != '0);
  assign b_nan   = (eb == EMAX) && (fb != '0);
  assign a_inf   = (ea == EMAX) && (fa == '0);
  assign b_inf   = (eb == EMAX) && (fb == '0);
  assign a_zero  = (ea == '0);              // flush-to-zero: fraction ignored
  assign b_zero  = (eb == '0);
  assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

  always_comb begin
    spec_word = {sa ^ sb, {(W-1){1'b0}}};
    if (a_nan || b_nan)                                  spec_word = QNAN;
    else if ((a_inf && b_zero) || (b_inf && a_zero))     spec_word = QNAN;
    else if (a_inf || b_inf)                             spec_word = {sa ^ sb, EMAX, {FRAC_W{1'b0}}};
  end

  // datapath state
  logic [PW-1:0]         acc;
  logic [MW-1:0]         ma, mb;
  logic [CW-1:0]         cnt;
  logic signed [EW-1:0]  e_r;
  logic                  sign_r, spec_r;
  logic [W-1:0]          spec_word_r;
  logic [MW:0]           psum;

  // Partial-product step: add the multiplicand into the upper half when the
  // current multiplier bit is set, then shift the whole accumulator right.
  assign psum = {1'b0, acc[PW-1:MW]} + {1'b0, ma & {MW{mb[0]}}};

  // rounding path
  logic [PW-2:0]         norm_f;           // normalised product without the leading one
  logic [FRAC_W-1:0]     frac_kept, r_frac;
  logic                  guard, sticky, up, r_carry, ovf, unf;
  logic signed [EW-1:0]  e_fin;
  logic [W-1:0]          norm_word;

  always_comb begin
    norm_f    = acc[PW-1] ? acc[PW-2:0] : {acc[PW-3:0], 1'b0};
    frac_kept = norm_f[PW-2:MW];
    guard     = norm_f[MW-1];
    sticky    = |norm_f[MW-2:0];
    up        = guard & (sticky | frac_kept[0]);
    // The hidden bit is always 1, so a carry out of the fraction is the
    // mantissa carry: fraction wraps to 0 and the exponent bumps.
    {r_carry, r_frac} = {1'b0, frac_kept} + {{FRAC_W{1'b0}}, up};
    e_fin     = e_r + EW'(acc[PW-1]) + EW'(r_carry);
    ovf       = (e_fin >= E_INF);
    unf       = (e_fin < E_ONE);
    if (ovf)      norm_word = {sign_r, EMAX, {FRAC_W{1'b0}}};
    else if (unf) norm_word = {sign_r, {(EXP_W+FRAC_W){1'b0}}};
    else          norm_word = {sign_r, e_fin[EXP_W-1:0], r_frac};
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state. Specials take one pass through ROUND, which only selects
  // the word computed at accept, so their result appears one edge after accept.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = special ? ROUND : CALC;
      CALC:    if (cnt == CW'(1)) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      ma          <= '0;
      mb          <= '0;
      cnt         <= '0;
      e_r         <= '0;
      sign_r      <= 1'b0;
      spec_r      <= 1'b0;
      spec_word_r <= '0;
      out_data    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          acc         <= '0;
          ma          <= {1'b1, fa};
          mb          <= {1'b1, fb};
          cnt         <= CW'(MW);
          e_r         <= $signed({2'b00, ea} + {2'b00, eb} - EW'(BIAS));
          sign_r      <= sa ^ sb;
          spec_r      <= special;
          spec_word_r <= spec_word;
        end
        CALC: begin
          acc <= {psum, acc[MW-1:1]};
          mb  <= mb >> 1;
          cnt <= cnt - CW'(1);
        end
        ROUND:   out_data <= spec_r ? spec_word_r : norm_word;
        default: ;
      endcase
    end
  end

`ifdef FP_MUL_FLAGS_EN
  logic spec_inv, spec_inv_r;
  assign spec_inv = !(a_nan || b_nan) && ((a_inf && b_zero) || (b_inf && a_zero));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec_inv_r <= 1'b0;
      out_flags  <= '0;
    end else if (state == IDLE && in_valid) begin
      spec_inv_r <= spec_inv;
    end else if (state == ROUND) begin
      if (spec_r) out_flags <= {spec_inv_r, 3'b000};
      else        out_flags <= {1'b0, ovf, unf, ovf | unf | guard | sticky};
    end
  end
`endif

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq (EXP_W=8, FRAC_W=23). Flag checks are active
// only when FP_MUL_FLAGS_EN is defined.
module tb_fp_mul_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         in_ready, out_valid;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic [W-1:0] out_data;
`ifdef FP_MUL_FLAGS_EN
  logic [3:0]   out_flags;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_mul_seq #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef FP_MUL_FLAGS_EN
    ,
    .out_flags (out_flags)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [3:0] exp);
`ifdef FP_MUL_FLAGS_EN
    chk(tag, {28'b0, out_flags}, {28'b0, exp});
`endif
  endtask

  // Present operands and let the next edge accept them.
  task automatic issue(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    chk({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = '1; in_b = '1;
  endtask

  // Count edges from accept until out_valid is seen; in_ready must stay low.
  task automatic wait_out(input string tag, input int exp_lat);
    int lat = 0;
    bit busy_bad = 1'b0;
    while (!out_valid && lat < 60) begin
      if (in_ready) busy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy"}, {31'b0, busy_bad}, 32'd0);
  endtask

  task automatic mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] exp_data, input logic [3:0] exp_flags, input int exp_lat);
    issue(tag, a, b);
    wait_out(tag, exp_lat);
    chk({tag, "_data"}, out_data, exp_data);
    chk_flags({tag, "_flags"}, exp_flags);
    // out_ready is high, so the handshake completes on the next edge
    @(posedge clk); #1;
    chk({tag, "_hs_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_hs_ready"}, {31'b0, in_ready}, 32'd1);
    chk({tag, "_hold"}, out_data, exp_data);
  endtask

  initial begin
    bit stable;
    // reset state
    #2;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk_flags("rst_flags", 4'h0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // main function
    mul("basic",   32'h3FC00000, 32'h40000000, 32'h40400000, 4'h0, 25);
    mul("sign",    32'hC0000000, 32'h40400000, 32'hC0C00000, 4'h0, 25);
    mul("tie",     32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'h1, 25);
    mul("sticky",  32'h3F800001, 32'h3F800001, 32'h3F800002, 4'h1, 25);
    mul("rcarry",  32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 4'h1, 25);
    mul("msb",     32'h40400000, 32'h40400000, 32'h41100000, 4'h0, 25);

    // special operands
    mul("inf_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'h8, 1);
    mul("zero_inf", 32'h00000000, 32'hFF800000, 32'h7FC00000, 4'h8, 1);
    mul("nan",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'h0, 1);
    mul("ninf",     32'hFF800000, 32'h40000000, 32'hFF800000, 4'h0, 1);
    mul("subn",     32'h00000001, 32'h3F800000, 32'h00000000, 4'h0, 1);

    // range limits
    mul("ovf",      32'h7F000000, 32'h40000000, 32'h7F800000, 4'h5, 25);
    mul("unf",      32'h00800000, 32'h3F000000, 32'h00000000, 4'h3, 25);

    // backpressure: hold DONE for 10 cycles while in_valid toggles
    out_ready = 1'b0;
    issue("bp", 32'h40400000, 32'h40400000);
    wait_out("bp", 25);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_a = 32'h3F800000; in_b = 32'h40000000; in_valid = i[0];
      @(posedge clk); #1;
      if (!(out_valid && !in_ready && out_data === 32'h41100000)) stable = 1'b0;
`ifdef FP_MUL_FLAGS_EN
      if (out_flags !== 4'h0) stable = 1'b0;
`endif
    end
    chk("bp_stable", {31'b0, stable}, 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_rel_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_rel_data", out_data, 32'h41100000);
    mul("bp_next", 32'h40400000, 32'h3F000000, 32'h3FC00000, 4'h0, 25);

    // asynchronous reset in the middle of CALC
    issue("abort", 32'h3FC00000, 32'h40000000);
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_out_data", out_data, 32'h0);
    #2 rst_n = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) stable = 1'b0;
    end
    chk("abort_no_result", {31'b0, out_valid}, 32'd0);
    mul("fresh", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'h0, 25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
